tc_cascade_counter: RTL and testbench
=====================================

Name: tc_cascade_counter

Overview:
- Downstream stage of the 4-bit `Counter`. It consumes the counter's `Q[3:0]` and `TC` outputs and counts terminal-count events into a higher-order count.
- Together with the low nibble it forms a wide cascaded count.
- Provides a registered carry-out for further cascading and a sticky overflow flag.
- Runs on the same clock as the upstream counter.

Parameters:
- WIDTH, 4: width of the high-order count `Q_hi`.
- WRAP, 1: 1 = wrap to 0 on overflow; 0 = saturate at max and halt until reset.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- MR  input  1  reset; synchronous, active-high.
- TC_in  input  1  terminal count from upstream 4-bit counter.
- Q_in  input  4  low nibble from upstream counter; passed into `Total` only.
- En  input  1  count enable for TC events.
- Clr  input  1  synchronous clear of `Q_hi` and `OVF`.
- Cap  input  1  capture strobe (used only with `CAPTURE_EN`).
- Q_hi  output  WIDTH  high-order count, registered.
- Total  output  WIDTH+4  combinational concatenation `{Q_hi, Q_in}`.
- TC_hi  output  1  one-cycle registered carry pulse on `Q_hi` max-to-next event.
- OVF  output  1  sticky overflow flag.
- Cap_val  output  WIDTH+4  captured `Total`.
- Cap_vld  output  1  one-cycle pulse when `Cap_val` is updated.

Behaviour:
- Reset values (MR=1 at a rising edge): `Q_hi`=0, `TC_hi`=0, `OVF`=0, `Cap_val`=0, `Cap_vld`=0, state=RUN. The internal TC history register `tc_d`=1, so a TC_in already high when reset is released is not counted.
- Event definition: `ev = TC_in & ~tc_d`. `tc_d` <= TC_in every non-reset cycle, including during `Clr`, `En`=0 and HALT. A TC held high for several cycles counts once.
- Latency: `Q_hi` and `TC_hi` change on the clock edge that samples the TC_in rising edge (1 cycle after TC_in goes high).
- Priority (highest first): MR > Clr > ev.
- `ev` with `En`=0 is dropped, not deferred.
- State machine:
  - RUN: on `ev & En`:
    - If `Q_hi` != 2^WIDTH-1: `Q_hi`+1.
    - If `Q_hi` == max: `TC_hi`=1 for that cycle and `OVF`<=1. With WRAP=1, `Q_hi`<=0 and stay in RUN. With WRAP=0, `Q_hi` holds max and go to HALT.
  - HALT: ignore `ev`; `Q_hi`=max, `OVF`=1. Exit to RUN on `Clr` (`Q_hi`=0, `OVF`=0) or MR.
- `Clr` in RUN: `Q_hi`<=0, `OVF`<=0, `TC_hi`<=0. A simultaneous `ev` is discarded.
- `TC_hi` is 0 in every cycle except the overflow cycle; never two consecutive cycles.
- Width: `Q_hi` increments modulo 2^WIDTH; no carry into `OVF` except at the max-to-next event.
- Reset mid-operation: MR overrides all, including a simultaneous `ev`, `Clr` or `Cap`.

Optional Feature:
- Macro: `TC_CASCADE_CAPTURE_EN`.
- Defined: on `Cap`=1 (not MR), `Cap_val`<=`Total` sampled that cycle (pre-increment `Q_hi`), and `Cap_vld`=1 for one cycle. `Cap` and `ev` in the same cycle: capture holds the old value, counting proceeds normally. `Cap` works in HALT.
- Undefined: ports remain; `Cap` is ignored; `Cap_val`=0 and `Cap_vld`=0 constantly; no capture flops synthesised.

Decomposition:
- Shared include `counter_defs.vh`:
  - State encodings `ST_RUN`=1'b0, `ST_HALT`=1'b1.
  - Default nibble width constant `NIB_W`=4.
  - Default `WIDTH`.
- Sub-module `tc_edge_det`: 1-bit rising-edge detector with reset-to-1 history register; outputs `ev`.

Test Plan:
- Reset release with TC_in=1 held: MR 1→0 while TC_in=1 → `Q_hi`=0, no count. Later TC_in 0→1 → `Q_hi`=1 one cycle after.
- WIDTH=4, WRAP=1, En=1: 16 single-cycle TC pulses → `Q_hi` 1..15 then 0. `TC_hi`=1 exactly on the 16th-event cycle, `OVF`=1 thereafter, `Total` = {0, Q_in}.
- WRAP=0: 17 pulses → `Q_hi` stays 15 from the 15th pulse. The 16th sets `OVF`/`TC_hi` and enters HALT; the 17th causes no change. `Clr` → `Q_hi`=0, `OVF`=0, counting resumes.
- Multi-cycle TC: TC_in high 3 cycles → `Q_hi` +1 only. Pulse with `En`=0 → no change, and not counted after `En` returns to 1.
- Priority: `Clr` and `ev` in the same cycle → `Q_hi`=0. MR, `Clr` and `ev` together → all outputs at reset values, `tc_d`=1.
- `TC_CASCADE_CAPTURE_EN`: `Q_hi`=5, Q_in=9, `Cap`=1 together with `ev` → `Cap_val`=0x59, `Cap_vld` for 1 cycle, `Q_hi`=6. Without the macro → `Cap_val`=0, `Cap_vld`=0.

Source files
------------

// File: rtl/tc_cascade_counter_pkg.sv
// Shared definitions for the TC cascade counter: FSM state encoding and
// default widths of the low nibble and the high-order count.
package tc_cascade_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam int NIB_W     = 4;
    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/tc_edge_det.sv
// Rising-edge detector whose history flop resets to 1, so an input already
// high when reset is released does not produce an event.
module tc_edge_det (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_d,
    output logic o_ev
);

    logic r_d;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_d <= 1'b1;
        end else begin
            r_d <= i_d;
        end
    end

    assign o_ev = i_d & ~r_d;

endmodule

// File: rtl/tc_cascade_counter.sv
// High-order stage of a cascaded counter: counts upstream TC rising edges,
// with carry-out pulse, sticky overflow and optional capture (TC_CASCADE_CAPTURE_EN).
module tc_cascade_counter
    import tc_cascade_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WRAP  = 1
) (
    input  logic                   Clk,
    input  logic                   MR,
    input  logic                   TC_in,
    input  logic [NIB_W-1:0]       Q_in,
    input  logic                   En,
    input  logic                   Clr,
    input  logic                   Cap,
    output logic [WIDTH-1:0]       Q_hi,
    output logic [WIDTH+NIB_W-1:0] Total,
    output logic                   TC_hi,
    output logic                   OVF,
    output logic [WIDTH+NIB_W-1:0] Cap_val,
    output logic                   Cap_vld
);

    localparam logic [WIDTH-1:0] Q_MAX = '1;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_q_hi, w_q_hi_next;
    logic             r_tc_hi, w_tc_hi_next;
    logic             r_ovf, w_ovf_next;
    logic             w_ev;

    tc_edge_det u_edge_det (
        .i_clk  (Clk),
        .i_srst (MR),
        .i_d    (TC_in),
        .o_ev   (w_ev)
    );

    always_ff @(posedge Clk) begin
        if (MR) begin
            r_state <= ST_RUN;
            r_q_hi  <= '0;
            r_tc_hi <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q_hi  <= w_q_hi_next;
            r_tc_hi <= w_tc_hi_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_q_hi_next  = r_q_hi;
        w_tc_hi_next = 1'b0;
        w_ovf_next   = r_ovf;
        if (Clr) begin
            // Clear wins over a same-cycle event and also releases HALT.
            w_state_next = ST_RUN;
            w_q_hi_next  = '0;
            w_ovf_next   = 1'b0;
        end else if (r_state == ST_RUN && w_ev && En) begin
            if (r_q_hi != Q_MAX) begin
                w_q_hi_next = r_q_hi + 1'b1;
            end else begin
                w_tc_hi_next = 1'b1;
                w_ovf_next   = 1'b1;
                if (WRAP != 0) begin
                    w_q_hi_next = '0;
                end else begin
                    w_state_next = ST_HALT;
                end
            end
        end
    end

    assign Q_hi  = r_q_hi;
    assign TC_hi = r_tc_hi;
    assign OVF   = r_ovf;
    assign Total = {r_q_hi, Q_in};

`ifdef TC_CASCADE_CAPTURE_EN
    logic [WIDTH+NIB_W-1:0] r_cap_val;
    logic                   r_cap_vld;

    // Samples Total before this cycle's increment lands in r_q_hi.
    always_ff @(posedge Clk) begin
        if (MR) begin
            r_cap_val <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_cap_vld <= Cap;
            if (Cap) begin
                r_cap_val <= Total;
            end
        end
    end

    assign Cap_val = r_cap_val;
    assign Cap_vld = r_cap_vld;
`else
    logic w_unused_cap;
    assign w_unused_cap = Cap;
    assign Cap_val      = '0;
    assign Cap_vld      = 1'b0;
`endif

endmodule

// File: tb/tb_tc_cascade_counter.sv
// Directed bench for tc_cascade_counter: a wrapping (WRAP=1) and a saturating
// (WRAP=0) instance share one stimulus stream.
module tb_tc_cascade_counter;

    logic       Clk = 1'b0;
    logic       MR, TC_in, En, Clr, Cap;
    logic [3:0] Q_in;

    logic [3:0] q_w, q_s;
    logic [7:0] total_w, total_s, capv_w, capv_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, capvld_w, capvld_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    tc_cascade_counter #(.WIDTH(4), .WRAP(1)) dut_wrap (
        .Clk(Clk), .MR(MR), .TC_in(TC_in), .Q_in(Q_in), .En(En), .Clr(Clr), .Cap(Cap),
        .Q_hi(q_w), .Total(total_w), .TC_hi(tc_w), .OVF(ovf_w),
        .Cap_val(capv_w), .Cap_vld(capvld_w)
    );

    tc_cascade_counter #(.WIDTH(4), .WRAP(0)) dut_sat (
        .Clk(Clk), .MR(MR), .TC_in(TC_in), .Q_in(Q_in), .En(En), .Clr(Clr), .Cap(Cap),
        .Q_hi(q_s), .Total(total_s), .TC_hi(tc_s), .OVF(ovf_s),
        .Cap_val(capv_s), .Cap_vld(capvld_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            TC_in = 1'b1;
            tick();
            TC_in = 1'b0;
            tick();
        end
    endtask

    initial begin
        MR = 1'b1; TC_in = 1'b1; En = 1'b1; Clr = 1'b0; Cap = 1'b0; Q_in = 4'h9;
        tick(); tick();
        check("reset q_hi", {28'd0, q_w}, 32'd0);
        check("reset tc_hi", {31'd0, tc_w}, 32'd0);
        check("reset ovf", {31'd0, ovf_w}, 32'd0);
        check("reset cap_val", {24'd0, capv_w}, 32'd0);
        check("reset cap_vld", {31'd0, capvld_w}, 32'd0);

        // Release reset with TC_in held high: must not count.
        MR = 1'b0;
        tick(); tick();
        check("no count on held TC", {28'd0, q_w}, 32'd0);
        TC_in = 1'b0; tick();
        TC_in = 1'b1; tick();
        check("first edge q_hi", {28'd0, q_w}, 32'd1);
        TC_in = 1'b0; tick();
        Clr = 1'b1; tick(); Clr = 1'b0;
        check("clr q_hi", {28'd0, q_w}, 32'd0);

        // 16 pulses: wrap instance rolls to 0, saturating one halts at 15.
        for (int i = 1; i <= 16; i++) begin
            TC_in = 1'b1;
            tick();
            check($sformatf("wrap q_hi #%0d", i), {28'd0, q_w}, i % 16);
            check($sformatf("wrap tc_hi #%0d", i), {31'd0, tc_w}, (i == 16) ? 1 : 0);
            check($sformatf("wrap ovf #%0d", i), {31'd0, ovf_w}, (i == 16) ? 1 : 0);
            check($sformatf("sat q_hi #%0d", i), {28'd0, q_s}, (i > 15) ? 15 : i);
            check($sformatf("sat tc_hi #%0d", i), {31'd0, tc_s}, (i == 16) ? 1 : 0);
            TC_in = 1'b0;
            tick();
            check($sformatf("tc_hi low after #%0d", i), {30'd0, tc_w, tc_s}, 32'd0);
        end
        check("wrap total", {24'd0, total_w}, 32'h09);
        check("sat ovf", {31'd0, ovf_s}, 32'd1);

        // 17th pulse: wrap counts on, saturated instance stays halted.
        pulse(1);
        check("wrap q_hi #17", {28'd0, q_w}, 32'd1);
        check("wrap ovf sticky", {31'd0, ovf_w}, 32'd1);
        check("wrap total #17", {24'd0, total_w}, 32'h19);
        check("sat q_hi halted", {28'd0, q_s}, 32'd15);
        check("sat ovf held", {31'd0, ovf_s}, 32'd1);

        Clr = 1'b1; tick(); Clr = 1'b0;
        check("clr q_hi both", {24'd0, q_w, q_s}, 32'd0);
        check("clr ovf both", {30'd0, ovf_w, ovf_s}, 32'd0);
        pulse(1);
        check("sat resumes", {28'd0, q_s}, 32'd1);

        // Multi-cycle TC counts once.
        TC_in = 1'b1; tick(); tick(); tick();
        TC_in = 1'b0; tick();
        check("multi-cycle TC", {28'd0, q_w}, 32'd2);

        // Event with En=0 is dropped, not deferred.
        En = 1'b0; TC_in = 1'b1; tick();
        En = 1'b1; tick();
        check("En=0 dropped", {28'd0, q_w}, 32'd2);
        TC_in = 1'b0; tick();

        // Clr beats a simultaneous event.
        TC_in = 1'b1; Clr = 1'b1; tick();
        check("clr over ev", {28'd0, q_w}, 32'd0);
        Clr = 1'b0; TC_in = 1'b0; tick();

        // MR with Clr, ev and Cap all at once.
        pulse(2);
        MR = 1'b1; Clr = 1'b1; TC_in = 1'b1; Cap = 1'b1; tick();
        check("mr q_hi", {28'd0, q_w}, 32'd0);
        check("mr tc_hi/ovf", {30'd0, tc_w, ovf_w}, 32'd0);
        check("mr cap", {23'd0, capv_w, capvld_w}, 32'd0);
        MR = 1'b0; Clr = 1'b0; Cap = 1'b0; tick();
        check("tc_d set by mr", {28'd0, q_w}, 32'd0);
        TC_in = 1'b0; tick();

        // Capture together with an event: captures pre-increment Total.
        pulse(5);
        check("q_hi before cap", {28'd0, q_w}, 32'd5);
        Q_in = 4'h9; Cap = 1'b1; TC_in = 1'b1; tick();
        check("q_hi after cap+ev", {28'd0, q_w}, 32'd6);
`ifdef TC_CASCADE_CAPTURE_EN
        check("cap_val", {24'd0, capv_w}, 32'h59);
        check("cap_vld pulse", {31'd0, capvld_w}, 32'd1);
`else
        check("cap_val", {24'd0, capv_w}, 32'h00);
        check("cap_vld pulse", {31'd0, capvld_w}, 32'd0);
`endif
        Cap = 1'b0; TC_in = 1'b0; tick();
        check("cap_vld drops", {31'd0, capvld_w}, 32'd0);
`ifdef TC_CASCADE_CAPTURE_EN
        check("cap_val held", {24'd0, capv_w}, 32'h59);
`else
        check("cap_val held", {24'd0, capv_w}, 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
